// File: rtl/reg_bank_cmd_ctrl.sv
// rtl/reg_bank_cmd_ctrl.sv - register bank command controller: in-order command FIFO driving bank pins, read responses on a stream
module reg_bank_cmd_ctrl #(
    parameter int ADDR_W     = 8,
    parameter int DATA_W     = 16,
    parameter int FIFO_DEPTH = 4,
    parameter int RD_LATENCY = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic [ADDR_W-1:0] rsp_addr,
    output logic [ADDR_W-1:0] bank_address,
    output logic [DATA_W-1:0] bank_data_in,
    output logic              bank_rw,
    input  logic [DATA_W-1:0] bank_data_out,
    output logic              busy
);

    localparam int IDX_W = $clog2(FIFO_DEPTH);
    localparam int PTR_W = IDX_W + 1;
    localparam logic [PTR_W-1:0] PTR_ONE  = 1;
    localparam logic [1:0]       CNT_INIT = 2'(RD_LATENCY - 1);

    typedef enum logic [2:0] {IDLE, WR, RD, CAP, RESP} state_t;

    state_t            state;
    logic [1:0]        lat_cnt;
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic              fifo_write [FIFO_DEPTH];
    logic [ADDR_W-1:0] fifo_addr  [FIFO_DEPTH];
    logic [DATA_W-1:0] fifo_data  [FIFO_DEPTH];

    logic empty;
    logic full;
    logic push;
    logic pop;
    logic [IDX_W-1:0] wr_idx;
    logic [IDX_W-1:0] rd_idx;

    // Extra pointer MSB separates the full and empty cases when the indices match.
    assign wr_idx    = wr_ptr[IDX_W-1:0];
    assign rd_idx    = rd_ptr[IDX_W-1:0];
    assign empty     = (wr_ptr == rd_ptr);
    assign full      = (wr_ptr[IDX_W] != rd_ptr[IDX_W]) && (wr_idx == rd_idx);
    assign cmd_ready = !full;
    assign push      = cmd_valid && !full;
    assign pop       = (state == IDLE) && !empty;
    assign busy      = (state != IDLE) || !empty;

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_write[wr_idx] <= cmd_write;
            fifo_addr[wr_idx]  <= cmd_addr;
            fifo_data[wr_idx]  <= cmd_wdata;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            lat_cnt      <= 2'd0;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            rsp_valid    <= 1'b0;
            rsp_rdata    <= '0;
            rsp_addr     <= '0;
            bank_address <= '0;
            bank_data_in <= '0;
            bank_rw      <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            case (state)
                IDLE: begin
                    if (!empty) begin
                        bank_address <= fifo_addr[rd_idx];
                        bank_data_in <= fifo_data[rd_idx];
                        bank_rw      <= fifo_write[rd_idx];
                        lat_cnt      <= CNT_INIT;
                        state        <= fifo_write[rd_idx] ? WR : RD;
                    end
                end
                WR: begin
                    bank_rw <= 1'b0;
                    state   <= IDLE;
                end
                RD: begin
                    if (lat_cnt == 2'd0) begin
                        state <= CAP;
                    end else begin
                        lat_cnt <= lat_cnt - 2'd1;
                    end
                end
                CAP: begin
                    rsp_rdata <= bank_data_out;
                    rsp_addr  <= bank_address;
                    rsp_valid <= 1'b1;
                    state     <= RESP;
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
